// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite encodings and the SRAM slave state type.
//   - htrans encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - hresp encodings (OKAY/ERROR)
//   - slave_state_t: data-phase FSM states of ahb_sram_slave
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: depth x data_width storage, one synchronous write port and
// one asynchronous read port.
//   hclk   in  clock for the write port
//   we     in  write enable
//   waddr  in  write word address
//   wdata  in  write data
//   raddr  in  read word address
//   rdata  out read data (combinational from raddr)
module ahb_sram_array #(
  parameter int addr_width = 8,
  parameter int data_width = 32,
  parameter int depth      = 2 ** addr_width
) (
  input  logic                  hclk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  localparam int idx_w = (depth > 1) ? $clog2(depth) : 1;

  logic [data_width-1:0] mem [depth];

  // NOTE: storage has no reset on purpose -- resetting an array turns it into
  // a huge register file and prevents SRAM macro mapping.
  always_ff @(posedge hclk) begin
    if (we) mem[waddr[idx_w-1:0]] <= wdata;
  end

  assign rdata = mem[raddr[idx_w-1:0]];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-lite slave backed by a word-addressed SRAM, with a
// fixed number of wait states per transfer and a two-cycle ERROR response for
// addresses at or beyond depth.
//   hclk, hresetn  clock, asynchronous active-low reset
//   hsel, htrans   transfer qualification (NONSEQ/SEQ with hsel)
//   haddr, hwrite  address-phase address and direction
//   hwdata         write data, sampled in the data phase
//   stall          extra wait request; stretches WAIT and LAST while high
//   hready, hresp  data-phase handshake and response
//   hrdata         read data, zero outside a completing read
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int addr_width  = 8,
  parameter int data_width  = 32,
  parameter int depth       = 2 ** addr_width,
  parameter int wait_states = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [addr_width-1:0] haddr,
  input  logic                  hwrite,
  input  logic [data_width-1:0] hwdata,
  input  logic                  stall,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic [data_width-1:0] hrdata
);

  localparam int wcnt_w = (wait_states > 0) ? $clog2(wait_states + 1) : 1;
  localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(depth);

  slave_state_t          state;
  logic [addr_width-1:0] addr_q;
  logic                  write_q;
  logic [wcnt_w-1:0]     wcnt;

  logic                  accept;
  logic                  addr_err;
  logic                  completing;
  logic [data_width-1:0] mem_rdata;

  assign accept     = hready && hsel && is_active(htrans);
  assign addr_err   = {1'b0, haddr} >= depth_lim;
  assign completing = (state == ST_LAST) && !stall;

  // Outputs decode directly from the registered state so an asynchronous
  // reset shows the idle response immediately; stall only gates LAST.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    unique case (state)
      ST_IDLE: hready = 1'b1;
      ST_WAIT: hready = 1'b0;
      ST_LAST: begin
        hready = !stall;
        if (completing && !write_q) hrdata = mem_rdata;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: hready = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the accept block
  // below relies on "last assignment wins" to override the default next state
  // when a new address phase overlaps the closing data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wcnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_WAIT: begin
          if (!stall) begin
            if (wcnt > wcnt_w'(1)) begin
              wcnt <= wcnt - 1'b1;
            end else begin
              wcnt  <= '0;
              state <= ST_LAST;
            end
          end
        end
        ST_LAST: if (!stall) state <= ST_IDLE;
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        wcnt    <= wcnt_w'(wait_states);
        if (addr_err)             state <= ST_ERR1;
        else if (wait_states > 0) state <= ST_WAIT;
        else                      state <= ST_LAST;
      end
    end
  end

  // Writes land only as LAST completes; error transfers never reach LAST.
  ahb_sram_array #(
    .addr_width (addr_width),
    .data_width (data_width),
    .depth      (depth)
  ) u_array (
    .hclk  (hclk),
    .we    (completing && write_q),
    .waddr (addr_q),
    .wdata (hwdata),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave. Three instances share the bus inputs and
// are told apart by hsel: [0] zero waits, [1] one wait with depth 16,
// [2] three waits.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  hsel_v;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        stall;
  logic [2:0]  hready_v;
  logic [1:0]  hresp_v [3];
  logic [31:0] hrdata_v [3];

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.addr_width(8), .data_width(32), .depth(256), .wait_states(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .stall(stall), .hready(hready_v[0]),
    .hresp(hresp_v[0]), .hrdata(hrdata_v[0]));

  ahb_sram_slave #(.addr_width(8), .data_width(32), .depth(16), .wait_states(1)) u_ws1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .stall(stall), .hready(hready_v[1]),
    .hresp(hresp_v[1]), .hrdata(hrdata_v[1]));

  ahb_sram_slave #(.addr_width(8), .data_width(32), .depth(256), .wait_states(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[2]), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .stall(stall), .hready(hready_v[2]),
    .hresp(hresp_v[2]), .hrdata(hrdata_v[2]));

  function automatic logic rdy();
    return hready_v[cur];
  endfunction

  function automatic logic [1:0] rsp();
    return hresp_v[cur];
  endfunction

  function automatic logic [31:0] rdat();
    return hrdata_v[cur];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, then settle before sampling.
  task automatic cyc(input logic s, input logic [1:0] t, input logic [7:0] a,
                     input logic w, input logic [31:0] d, input logic st);
    @(negedge hclk);
    hsel_v = s ? (3'b001 << cur) : 3'b000;
    htrans = t;
    haddr  = a;
    hwrite = w;
    hwdata = d;
    stall  = st;
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input string tag);
    cyc(1'b1, HTRANS_NONSEQ, a, 1'b1, 32'h0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, d, 1'b0);
      if (rdy()) break;
    end
    check({tag, "_done"}, 32'(rdy()), 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    cyc(1'b1, HTRANS_NONSEQ, a, 1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
      if (rdy()) break;
    end
    check({tag, "_done"}, 32'(rdy()), 32'd1);
    check({tag, "_data"}, rdat(), exp);
    check({tag, "_resp"}, 32'(rsp()), 32'(HRESP_OKAY));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    hresetn = 1'b0;
    hsel_v  = 3'b000;
    htrans  = HTRANS_IDLE;
    haddr   = 8'h00;
    hwrite  = 1'b0;
    hwdata  = 32'h0;
    stall   = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      check("rst_hready", 32'(rdy()), 32'd1);
      check("rst_hresp", 32'(rsp()), 32'(HRESP_OKAY));
      check("rst_hrdata", rdat(), 32'h0);
    end
    @(negedge hclk);
    hresetn = 1'b1;

    // ---- zero wait states: pipelined write then read of 0x10 ----
    cur = 0;
    cyc(1'b1, HTRANS_NONSEQ, 8'h10, 1'b1, 32'h0, 1'b0);
    check("w0_addr_hready", 32'(rdy()), 32'd1);
    cyc(1'b1, HTRANS_NONSEQ, 8'h10, 1'b0, 32'hDEADBEEF, 1'b0);
    check("w0_wdata_hready", 32'(rdy()), 32'd1);
    check("w0_wdata_hrdata", rdat(), 32'h0);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
    check("w0_rd_hready", 32'(rdy()), 32'd1);
    check("w0_rd_hrdata", rdat(), 32'hDEADBEEF);
    check("w0_rd_hresp", 32'(rsp()), 32'(HRESP_OKAY));
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
    check("w0_idle_hready", 32'(rdy()), 32'd1);
    check("w0_idle_hrdata", rdat(), 32'h0);

    // ---- back-to-back RAW then WAR on 0x01 ----
    cyc(1'b1, HTRANS_NONSEQ, 8'h01, 1'b1, 32'h0, 1'b0);
    cyc(1'b1, HTRANS_NONSEQ, 8'h01, 1'b0, 32'h11111111, 1'b0);
    cyc(1'b1, HTRANS_NONSEQ, 8'h01, 1'b1, 32'h0, 1'b0);
    check("raw_hrdata", rdat(), 32'h11111111);
    check("raw_hready", 32'(rdy()), 32'd1);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h22222222, 1'b0);
    check("war_wphase_hrdata", rdat(), 32'h0);
    do_read(8'h01, 32'h22222222, "war_readback");

    // ---- BUSY with hsel high is not a transfer ----
    cyc(1'b1, HTRANS_BUSY, 8'h10, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0BAD0BAD, 1'b0);
    check("busy_hready", 32'(rdy()), 32'd1);
    check("busy_hresp", 32'(rsp()), 32'(HRESP_OKAY));
    do_read(8'h10, 32'hDEADBEEF, "busy_readback");

    // ---- three wait states ----
    cur = 2;
    do_write(8'h20, 32'h5A5A5A5A, "ws3_wr");
    cyc(1'b1, HTRANS_NONSEQ, 8'h20, 1'b0, 32'h0, 1'b0);
    lows = 0;
    for (int n = 0; n < 10; n++) begin
      cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
      if (rdy()) break;
      lows++;
    end
    check("ws3_low_cycles", 32'(lows), 32'd3);
    check("ws3_hrdata", rdat(), 32'h5A5A5A5A);
    check("ws3_hresp", 32'(rsp()), 32'(HRESP_OKAY));
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
    check("ws3_idle_hrdata", rdat(), 32'h0);

    // ---- depth 16, one wait: out-of-range write ----
    cur = 1;
    do_write(8'h00, 32'hA5A50000, "d16_pre0");
    do_write(8'h03, 32'h33333333, "d16_pre3");
    cyc(1'b1, HTRANS_NONSEQ, 8'h20, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'hFFFFFFFF, 1'b1);
    check("err1_hready", 32'(rdy()), 32'd0);
    check("err1_hresp", 32'(rsp()), 32'(HRESP_ERROR));
    cyc(1'b1, HTRANS_NONSEQ, 8'h00, 1'b0, 32'hFFFFFFFF, 1'b0);
    check("err2_hready", 32'(rdy()), 32'd1);
    check("err2_hresp", 32'(rsp()), 32'(HRESP_ERROR));
    check("err2_hrdata", rdat(), 32'h0);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
    check("err_next_wait_hready", 32'(rdy()), 32'd0);
    check("err_next_wait_hresp", 32'(rsp()), 32'(HRESP_OKAY));
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, 1'b0);
    check("err_next_hready", 32'(rdy()), 32'd1);
    check("err_next_hrdata", rdat(), 32'hA5A50000);
    check("err_next_hresp", 32'(rsp()), 32'(HRESP_OKAY));

    // ---- one wait plus two stall cycles ----
    cyc(1'b1, HTRANS_NONSEQ, 8'h03, 1'b0, 32'h0, 1'b0);
    lows = 0;
    for (int n = 0; n < 10; n++) begin
      cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'h0, (n < 2));
      if (rdy()) break;
      lows++;
    end
    check("stall_low_cycles", 32'(lows), 32'd3);
    check("stall_hrdata", rdat(), 32'h33333333);
    check("stall_hresp", 32'(rsp()), 32'(HRESP_OKAY));

    // ---- asynchronous reset during the WAIT of a write ----
    do_write(8'h05, 32'h12345678, "rst_pre");
    cyc(1'b1, HTRANS_NONSEQ, 8'h05, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, HTRANS_IDLE, 8'h00, 1'b0, 32'hCAFEF00D, 1'b1);
    check("rst_wait_hready", 32'(rdy()), 32'd0);
    #1 hresetn = 1'b0;
    #1;
    check("rst_mid_hready", 32'(rdy()), 32'd1);
    check("rst_mid_hresp", 32'(rsp()), 32'(HRESP_OKAY));
    check("rst_mid_hrdata", rdat(), 32'h0);
    @(negedge hclk);
    stall   = 1'b0;
    hresetn = 1'b1;
    do_read(8'h05, 32'h12345678, "rst_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
